// File: rtl/a2d_sched.sv
// Round-robin ADC128S conversion scheduler (left load, right load, battery) for the shared A2D SPI master.
// Optional macro A2D_FILT_EN: IIR-filter each reading as (3*old + new) >> 2, seeded by the first capture.
module a2d_sched #(
    parameter int         PERIOD  = 4096,
    parameter int         TIMEOUT = 1024,
    parameter logic [2:0] CH_LFT  = 3'd0,
    parameter logic [2:0] CH_RGHT = 3'd4,
    parameter logic [2:0] CH_BATT = 3'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        vld,
    output logic        err
);

    localparam int PW = $clog2(PERIOD);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t           state;
    logic [1:0]       idx;
    logic [PW-1:0]    pcnt;
    logic [TW-1:0]    tcnt;
    logic             tick;
    logic [2:0][11:0] ld_q;
    logic [11:0]      rd_val;
    logic             cap_en;
    logic [1:0]       cap_ch;
    logic             unused_rd_hi;

    assign rd_val       = spi_rd_data[11:0];
    assign unused_rd_hi = ^spi_rd_data[15:12];
    assign tick         = en && (pcnt == PER_LAST);

    // The ADC returns the previous transaction's channel, so idx k fills slot k-1.
    assign cap_en = (state == WAIT) && spi_done && (idx != 2'd0);
    assign cap_ch = idx - 2'd1;

    assign lft_ld  = ld_q[0];
    assign rght_ld = ld_q[1];
    assign batt    = ld_q[2];

    function automatic logic [15:0] cmd_for(input logic [1:0] i);
        logic [2:0] ch;
        case (i)
            2'd0:    ch = CH_LFT;
            2'd1:    ch = CH_RGHT;
            default: ch = CH_BATT;
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (!en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            tcnt    <= '0;
            spi_wrt <= 1'b0;
            spi_cmd <= '0;
            vld     <= 1'b0;
            err     <= 1'b0;
        end else begin
            spi_wrt <= 1'b0;
            vld     <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        idx     <= 2'd0;
                        spi_cmd <= cmd_for(2'd0);
                        spi_wrt <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    tcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (spi_done) begin
                        if (idx == 2'd3) begin
                            vld   <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx     <= idx + 2'd1;
                            spi_cmd <= cmd_for(idx + 2'd1);
                            spi_wrt <= 1'b1;
                            state   <= SEND;
                        end
                    end else if (tcnt == TO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef A2D_FILT_EN
    logic [2:0] seeded;

    function automatic logic [11:0] filt(input logic [11:0] old_v, input logic [11:0] new_v);
        logic [13:0] sum;
        sum = 14'(old_v) * 14'd3 + 14'(new_v);
        return sum[13:2];
    endfunction
`endif

    // NOTE: the reading registers are reset because the outputs must read 0
    // after rst; three words is cheap enough that a reset costs nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_q <= '0;
`ifdef A2D_FILT_EN
            seeded <= '0;
`endif
        end else if (cap_en) begin
`ifdef A2D_FILT_EN
            ld_q[cap_ch]   <= seeded[cap_ch] ? filt(ld_q[cap_ch], rd_val) : rd_val;
            seeded[cap_ch] <= 1'b1;
`else
            ld_q[cap_ch] <= rd_val;
`endif
        end
    end

endmodule

// File: tb/tb_a2d_sched.sv
// Directed bench for a2d_sched: pipelined ADC/SPI model, timeout, dropped ticks, en drop, rst, filter.
module tb_a2d_sched;

    localparam int P  = 64;
    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        rst, en, spi_wrt, spi_done, vld, err;
    logic [15:0] spi_cmd, spi_rd_data;
    logic [11:0] lft_ld, rght_ld, batt;

    a2d_sched #(.PERIOD(P), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .en(en),
        .spi_wrt(spi_wrt), .spi_cmd(spi_cmd),
        .spi_done(spi_done), .spi_rd_data(spi_rd_data),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
        .vld(vld), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [11:0] lft_val  = 12'h100;
    logic [11:0] rght_val = 12'h200;
    logic [11:0] batt_val = 12'h3A0;
    int lat = 2;
    int drop_at = -1;
    int wrt_cnt = 0, vld_cnt = 0;
    int last_wrt_cyc = 0, last_done_cyc = 0, last_vld_cyc = 0, prev_vld_cyc = 0;
    int drop_cyc = 0, err_cyc = -1;
    logic [11:0] vld_batt = '0;
    logic [15:0] cmd_q[$];
    logic        pending = 1'b0;
    int          lat_left = 0;
    logic [2:0]  cur_ch = 3'd7, prev_ch = 3'd7;

    function automatic logic [11:0] adc_val(input logic [2:0] ch);
        case (ch)
            3'd0:    return lft_val;
            3'd4:    return rght_val;
            3'd5:    return batt_val;
            default: return 12'hFFF;
        endcase
    endfunction

    // ADC/SPI model plus event monitor, all away from the active edge.
    always @(negedge clk) begin
        spi_done = 1'b0;
        if (rst) begin
            pending = 1'b0;
            prev_ch = 3'd7;
        end else begin
            if (pending) begin
                if (lat_left == 0) begin
                    spi_done      = 1'b1;
                    spi_rd_data   = {4'hA, adc_val(prev_ch)};
                    prev_ch       = cur_ch;
                    pending       = 1'b0;
                    last_done_cyc = cyc;
                end else begin
                    lat_left--;
                end
            end
            if (spi_wrt) begin
                wrt_cnt++;
                cmd_q.push_back(spi_cmd);
                last_wrt_cyc = cyc;
                if (wrt_cnt == drop_at) begin
                    drop_cyc = cyc;
                end else begin
                    pending  = 1'b1;
                    cur_ch   = spi_cmd[13:11];
                    lat_left = lat;
                end
            end
        end
        if (vld) begin
            vld_cnt++;
            prev_vld_cyc = last_vld_cyc;
            last_vld_cyc = cyc;
            vld_batt     = batt;
        end
        if (err && err_cyc < 0) err_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0:       return wrt_cnt;
            1:       return vld_cnt;
            default: return (err_cyc >= 0) ? 1 : 0;
        endcase
    endfunction

    // Bounded wait on a monitor counter; an expired budget is a failed check.
    task automatic wait_for(input string tag, input int which, input int target, input int budget);
        int n = 0;
        while (cnt_of(which) < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(tag, 32'(cnt_of(which) >= target), 32'd1);
        #2;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int en_cyc, base, v0, round_start;

    initial begin
        rst = 1'b1; en = 1'b0; spi_done = 1'b0; spi_rd_data = '0;
        step(3);
        check("rst_wrt",  32'(spi_wrt), 0);
        check("rst_cmd",  32'(spi_cmd), 0);
        check("rst_outs", 32'({lft_ld, rght_ld, batt} != 36'd0), 0);
        check("rst_flags", 32'({vld, err}), 0);

        // Normal rounds
        rst = 1'b0; en = 1'b1; en_cyc = cyc;
        wait_for("first_wrt", 0, 1, P + 10);
        check("first_wrt_lat", last_wrt_cyc - en_cyc, P);
        wait_for("first_vld", 1, 1, 100);
        check("cmd0", 32'(cmd_q[0]), 32'h0000);
        check("cmd1", 32'(cmd_q[1]), 32'h2000);
        check("cmd2", 32'(cmd_q[2]), 32'h2800);
        check("cmd3", 32'(cmd_q[3]), 32'h2800);
        check("round_wrts", wrt_cnt, 4);
        check("vld_after_done", last_vld_cyc - last_done_cyc, 1);
        check("batt_at_vld", 32'(vld_batt), 32'h3A0);
        check("lft", 32'(lft_ld), 32'h100);
        check("rght", 32'(rght_ld), 32'h200);
        check("batt", 32'(batt), 32'h3A0);
        wait_for("steady_vld", 1, 4, 3 * P + 20);
        check("vld_spacing", last_vld_cyc - prev_vld_cyc, P);
        check("steady_wrts", wrt_cnt, 16);
        check("cmd13", 32'(cmd_q[13]), 32'h2000);

        // Reset while waiting on idx1
        base = wrt_cnt;
        wait_for("rst_idx1", 0, base + 2, P + 20);
        rst = 1'b1;
        #1;
        check("rst_async_lft", 32'(lft_ld), 0);
        check("rst_async_cmd", 32'(spi_cmd), 0);
        check("rst_async_data", 32'({rght_ld, batt}), 0);
        step(2);
        rst = 1'b0; en_cyc = cyc; base = wrt_cnt; v0 = vld_cnt;
        wait_for("post_rst_wrt", 0, base + 1, P + 10);
        check("post_rst_lat", last_wrt_cyc - en_cyc, P);
        wait_for("post_rst_vld", 1, v0 + 1, 100);
        check("post_rst_err", 32'(err), 0);
        check("post_rst_lft", 32'(lft_ld), 32'h100);
        check("post_rst_batt", 32'(batt), 32'h3A0);

        // Timeout on idx2
        rst = 1'b1;
        step(1);
        rst = 1'b0; err_cyc = -1; lft_val = 12'h140;
        base = wrt_cnt; v0 = vld_cnt; drop_at = base + 3;
        wait_for("to_err", 2, 1, P + TO + 60);
        check("to_latency", err_cyc - drop_cyc, TO + 1);
        check("to_no_vld", vld_cnt, v0);
        check("to_wrts", wrt_cnt, base + 3);
        check("to_lft", 32'(lft_ld), 32'h140);
        check("to_rght", 32'(rght_ld), 0);
        check("to_batt", 32'(batt), 0);
        drop_at = -1;
        wait_for("to_next_vld", 1, v0 + 1, 2 * P + 60);
        check("to_err_sticky", 32'(err), 1);
        check("to_next_wrts", wrt_cnt, base + 7);
        check("to_next_rght", 32'(rght_ld), 32'h200);
        check("to_next_batt", 32'(batt), 32'h3A0);

        // Done delayed past a period: mid-round tick dropped
        lat = 100; base = wrt_cnt; v0 = vld_cnt;
        wait_for("dly_start", 0, base + 1, P + 10);
        round_start = last_wrt_cyc;
        wait_for("dly_vld", 1, v0 + 1, 600);
        check("dly_wrts", wrt_cnt - base, 4);
        check("dly_vlds", vld_cnt - v0, 1);
        lat = 2;
        wait_for("dly_next", 0, base + 5, P + 10);
        check("dly_tick_phase", (last_wrt_cyc - round_start) % P, 0);
        wait_for("dly_next_vld", 1, v0 + 2, 100);

        // en dropped during idx1
        base = wrt_cnt; v0 = vld_cnt;
        wait_for("en_idx1", 0, base + 2, P + 20);
        en = 1'b0;
        wait_for("en_vld", 1, v0 + 1, 60);
        step(3 * P + 10);
        check("en_off_wrts", wrt_cnt, base + 4);
        en = 1'b1; en_cyc = cyc;
        wait_for("en_back", 0, base + 5, P + 10);
        check("en_back_lat", last_wrt_cyc - en_cyc, P);

        // Battery sequence 0x400 then 0x800 from a fresh reset
        rst = 1'b1;
        step(1);
        rst = 1'b0; batt_val = 12'h400; v0 = vld_cnt;
        wait_for("f1_vld", 1, v0 + 1, P + 60);
        check("f1_batt", 32'(batt), 32'h400);
        batt_val = 12'h800;
        wait_for("f2_vld", 1, v0 + 2, P + 60);
`ifdef A2D_FILT_EN
        check("f2_batt", 32'(batt), 32'h500);
`else
        check("f2_batt", 32'(batt), 32'h800);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish by 500000");
        $fatal(1);
    end

endmodule

// File: doc/a2d_sched.md
Name: a2d_sched

Overview:
Round-robin conversion scheduler for the DE0 A2D (ADC128S) path of the Segway. It sequences the shared SPI master through left load cell, right load cell and battery conversions on a fixed sample period. It accounts for the ADC's one-transaction result pipeline and presents registered 12-bit readings to balance/steer/piezo logic with a round-complete strobe. It sits between the A2D SPI master and the rest of the Segway core.

Parameters:
PERIOD, 4096, clocks between round starts (≥ 64)
TIMEOUT, 1024, max clocks waiting for spi_done before abort
CH_LFT, 3'd0, ADC channel of left load cell
CH_RGHT, 3'd4, ADC channel of right load cell
CH_BATT, 3'd5, ADC channel of battery

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, reset asynchronous and active-high
en  in  1  enables period counter / new rounds
spi_wrt  out  1  one-cycle start pulse to SPI master
spi_cmd  out  16  command word, held stable from spi_wrt until spi_done
spi_done  in  1  one-cycle pulse, transaction complete
spi_rd_data  in  16  MISO word, valid in spi_done cycle
lft_ld  out  12  left load cell reading
rght_ld  out  12  right load cell reading
batt  out  12  battery reading
vld  out  1  one-cycle pulse: round completed, all three outputs updated
err  out  1  sticky: timeout occurred; cleared only by rst

Behaviour:
- Reset: all outputs 0, period counter 0, idx 0, state IDLE.
- Period counter: counts while en=1, holds at 0 while en=0; tick when count==PERIOD-1, then wraps to 0.
- Command format: spi_cmd = {2'b00, ch[2:0], 11'h000}.
- Round = 4 transactions, idx 0..3, channels CH_LFT, CH_RGHT, CH_BATT, CH_BATT (dummy). Result of transaction k belongs to transaction k-1's channel: done of idx1 -> lft_ld, idx2 -> rght_ld, idx3 -> batt; idx0 result discarded.
- Captured value = spi_rd_data[11:0]; registered in the cycle after spi_done.
- FSM:
  - IDLE: tick -> SEND, idx=0.
  - SEND: spi_wrt=1 for exactly this cycle; spi_cmd driven for idx; timeout counter cleared -> WAIT.
  - WAIT: on spi_done capture per idx; idx<3 -> idx+1, SEND; idx==3 -> DONE. Timeout counter reaching TIMEOUT-1 without done -> err=1, IDLE, outputs keep previous values, no vld.
  - DONE: vld=1 one cycle -> IDLE.
- First spi_wrt follows tick by 1 clock; vld is 1 clock after last capture.
- Tick while not IDLE: dropped, no queueing.
- en deasserted mid-round: current round completes normally, including vld; no further ticks.
- spi_done in IDLE/SEND/DONE: ignored.
- spi_cmd holds last value in IDLE.
- rst mid-round: immediate return to reset state; spi_wrt low asynchronously.

Optional Feature:
A2D_FILT_EN
- Defined: each captured reading is IIR-filtered: out <= (3*out + new) >> 2, computed at 14 bits, truncated to 12. The first capture after reset per channel loads new directly, tracked by a per-channel seeded flag.
- Undefined: raw load as above; no filter logic.

Test Plan:
- PERIOD=64, en=1, SPI model returns 12'h100/12'h200/12'h3A0 for ch0/4/5, pipelined -> cmds 0x0000,0x2000,0x2800,0x2800 per round. Outputs 0x100/0x200/0x3A0; vld one pulse per 64 clocks; first spi_wrt 1 clk after tick.
- Model withholds spi_done on idx2 -> err=1 after TIMEOUT clocks, no vld, lft_ld updated and rght_ld/batt unchanged; next tick starts a fresh round with err still 1.
- Model delays done longer than PERIOD -> mid-round tick dropped; exactly one round, one vld, no extra spi_wrt.
- en dropped during idx1 -> round finishes with vld, then no spi_wrt for ≥ 3 periods; re-enable -> first wrt after PERIOD clocks.
- rst asserted in WAIT -> all outputs 0 same cycle; after release with en=1, normal round follows; err 0.
- A2D_FILT_EN: batt readings 0x400, then 0x800 -> batt 0x400 after round 1, 0x500 after round 2.
